// File: rtl/network_div_div_27s_11ns_16_seq.sv
// ============================================================================
// network_div_div_27s_11ns_16_seq
//
// Sequential restoring divider. It undoes the network's 16s x 11ns -> 27-bit
// scaling multiply on the requantise path between the accumulator and the
// activation stream.
//
// The dividend is signed. The divisor is unsigned. The quotient is truncated
// toward zero and saturated to 16-bit signed. The remainder carries the
// dividend's sign. One quotient bit is produced per clock, MSB first.
//
// Ports
//   ap_clk     in   1            clock, rising edge
//   ap_rst     in   1            synchronous active-high reset
//   in_valid   in   1            operands valid
//   in_ready   out  1            block can accept operands (high only in IDLE)
//   din0       in   DIVIDEND_W   dividend, signed
//   din1       in   DIVISOR_W    divisor, unsigned
//   out_valid  out  1            result valid (high only in DONE)
//   out_ready  in   1            consumer accepts result
//   dout       out  QUOT_W       quotient, signed, saturating
//   rem        out  REM_W        remainder, signed
//   ovf        out  1            quotient was saturated
//   div0       out  1            divisor was zero
// ============================================================================
`default_nettype none

module network_div_div_27s_11ns_16_seq #(
    parameter int DIVIDEND_W = 27,
    parameter int DIVISOR_W  = 11,
    parameter int QUOT_W     = 16,
    parameter int REM_W      = DIVISOR_W + 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     dout,
    output logic [REM_W-1:0]      rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);

    // Magnitude limits for the signed quotient: +32767 and 32768 (for -32768).
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((2 ** (QUOT_W - 1)) - 1);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(2 ** (QUOT_W - 1));
    localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W - 1){1'b1}}};
    localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg,  state_next;
    logic                   neg_reg,    neg_next;
    // Shared shift register: dividend bits leave at the top and quotient
    // bits enter at the bottom. After DIVIDEND_W steps it holds |quotient|.
    logic [DIVIDEND_W-1:0]  mag_reg,    mag_next;
    logic [DIVISOR_W-1:0]   dvs_reg,    dvs_next;
    // The partial remainder is always below the divisor, so DIVISOR_W bits
    // are enough to hold it between steps.
    logic [DIVISOR_W-1:0]   r_reg,      r_next;
    logic [CNT_W-1:0]       count_reg,  count_next;
    logic [QUOT_W-1:0]      dout_reg,   dout_next;
    logic [REM_W-1:0]       rem_reg,    rem_next;
    logic                   ovf_reg,    ovf_next;
    logic                   div0_reg,   div0_next;

    // One restoring step, computed from the current registers.
    logic [DIVISOR_W:0]     r_shift;
    logic [DIVISOR_W-1:0]   r_sub;
    logic                   q_bit;
    logic [DIVISOR_W-1:0]   r_step;
    logic [DIVIDEND_W-1:0]  q_step;
    logic [REM_W-1:0]       r_ext;

    always_comb begin
        r_shift = {r_reg, mag_reg[DIVIDEND_W-1]};
        q_bit   = (r_shift >= {1'b0, dvs_reg});
        // Modulo subtraction is exact here because the result is below the
        // divisor whenever it is used.
        r_sub   = r_shift[DIVISOR_W-1:0] - dvs_reg;
        r_step  = q_bit ? r_sub : r_shift[DIVISOR_W-1:0];
        q_step  = {mag_reg[DIVIDEND_W-2:0], q_bit};
        r_ext   = {1'b0, r_step};
    end

    always_comb begin
        state_next = state_reg;
        neg_next   = neg_reg;
        mag_next   = mag_reg;
        dvs_next   = dvs_reg;
        r_next     = r_reg;
        count_next = count_reg;
        dout_next  = dout_reg;
        rem_next   = rem_reg;
        ovf_next   = ovf_reg;
        div0_next  = div0_reg;

        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    neg_next = din0[DIVIDEND_W-1];
                    // The two's-complement negate of -2^(W-1) gives the same
                    // bit pattern. Read as unsigned, that is exactly 2^(W-1).
                    mag_next = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;
                    dvs_next = din1;
                    if (din1 == '0) begin
                        // Skip the iteration entirely. The result is ready
                        // one cycle after the operands are accepted.
                        dout_next  = din0[DIVIDEND_W-1] ? Q_MIN : Q_MAX;
                        rem_next   = '0;
                        ovf_next   = 1'b0;
                        div0_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        r_next     = '0;
                        count_next = CNT_INIT;
                        state_next = CALC;
                    end
                end
            end

            CALC: begin
                r_next     = r_step;
                mag_next   = q_step;
                count_next = count_reg - 1'b1;
                if (count_reg == '0) begin
                    div0_next = 1'b0;
                    if (!neg_reg) begin
                        if (q_step > POS_LIM) begin
                            dout_next = Q_MAX;
                            ovf_next  = 1'b1;
                        end else begin
                            dout_next = q_step[QUOT_W-1:0];
                            ovf_next  = 1'b0;
                        end
                        rem_next = r_ext;
                    end else begin
                        if (q_step > NEG_LIM) begin
                            dout_next = Q_MIN;
                            ovf_next  = 1'b1;
                        end else begin
                            // A magnitude of exactly 32768 negates to -32768.
                            dout_next = ~q_step[QUOT_W-1:0] + 1'b1;
                            ovf_next  = 1'b0;
                        end
                        rem_next = ~r_ext + 1'b1;
                    end
                    state_next = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg <= IDLE;
            neg_reg   <= 1'b0;
            mag_reg   <= '0;
            dvs_reg   <= '0;
            r_reg     <= '0;
            count_reg <= '0;
            dout_reg  <= '0;
            rem_reg   <= '0;
            ovf_reg   <= 1'b0;
            div0_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            neg_reg   <= neg_next;
            mag_reg   <= mag_next;
            dvs_reg   <= dvs_next;
            r_reg     <= r_next;
            count_reg <= count_next;
            dout_reg  <= dout_next;
            rem_reg   <= rem_next;
            ovf_reg   <= ovf_next;
            div0_reg  <= div0_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign dout      = dout_reg;
    assign rem       = rem_reg;
    assign ovf       = ovf_reg;
    assign div0      = div0_reg;

endmodule

`default_nettype wire

// File: tb/tb_network_div_div_27s_11ns_16_seq.sv
// ============================================================================
// tb_network_div_div_27s_11ns_16_seq
//
// Scoreboard bench for the sequential signed divider.
//
// The driver issues operands. For each accepted operation it pushes the
// expected response, computed with plain integer division and saturation,
// into a queue. A separate monitor checks every cycle in which out_valid is
// high against the head of the queue. It pops the head on the handshake.
// ============================================================================
`timescale 1ns/1ps

module tb_network_div_div_27s_11ns_16_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] din0;
    logic [10:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic [11:0] rem;
    logic        ovf;
    logic        div0;

    network_div_div_27s_11ns_16_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .rem       (rem),
        .ovf       (ovf),
        .div0      (div0)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int o;
        int z;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: integer division truncates toward zero, and % takes the
    // dividend's sign. Saturation is applied on top of that.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   qt;
        e.a = a;
        e.b = b;
        e.acc = 0;
        if (b == 0) begin
            e.q   = (a >= 0) ? 32767 : -32768;
            e.r   = 0;
            e.o   = 0;
            e.z   = 1;
            e.lat = 1;
        end else begin
            qt    = a / b;
            e.r   = a % b;
            e.z   = 0;
            e.lat = 28;
            if (qt > 32767) begin
                e.q = 32767;
                e.o = 1;
            end else if (qt < -32768) begin
                e.q = -32768;
                e.o = 1;
            end else begin
                e.q = qt;
                e.o = 0;
            end
        end
        return e;
    endfunction

    // Present operands until accepted. If expect_it is set, queue the expected result.
    task automatic issue(input int a, input int b, input bit expect_it);
        int   n;
        exp_t e;
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0     = a[26:0];
        din1     = b[10:0];
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", in_ready, 1);
        end else if (expect_it) begin
            e = model(a, b);
            e.acc = cyc + 1;
            sb.push_back(e);
            $display("issue %0d / %0d -> exp q=%0d r=%0d ovf=%0d div0=%0d", a, b, e.q, e.r, e.o, e.z);
        end else begin
            $display("issue %0d / %0d (to be aborted)", a, b);
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 1000) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor
    bit seen = 1'b0;
    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
                    seen = 1'b1;
                end
                chk("dout", $signed(dout), sb[0].q);
                chk("rem", $signed(rem), sb[0].r);
                chk("ovf", ovf, sb[0].o);
                chk("div0", div0, sb[0].z);
                chk("in_ready_in_done", in_ready, 0);
                if (out_ready) begin
                    $display("result %0d / %0d: dout=%0d rem=%0d ovf=%0d div0=%0d",
                             sb[0].a, sb[0].b, $signed(dout), $signed(rem), ovf, div0);
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Consumer ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Watchdog
    initial begin
        repeat (60000) @(posedge ap_clk);
        total++;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    int dir_a [9] = '{1000, -1000, -7, 5, 67108863, -67108864, -32768, 500, -500};
    int dir_b [9] = '{7, 7, 7, 2047, 1, 2047, 1, 0, 0};

    initial begin
        int          n;
        int          a;
        int          b;
        logic [26:0] t;

        ap_rst   = 1'b1;
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_rem", rem, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_div0", div0, 0);

        // Directed operations
        for (int i = 0; i < 9; i++) begin
            issue(dir_a[i], dir_b[i], 1'b1);
            wait_drain();
        end

        // Backpressure, plus an in_valid pulse during CALC
        rdy_mode = 2;
        issue(12345, 37, 1'b1);
        repeat (4) @(negedge ap_clk);
        in_valid = 1'b1;
        din0     = 27'd999;
        din1     = 11'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            chk("in_ready_in_calc", in_ready, 0);
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk("bp_out_valid", out_valid, 1);
        repeat (10) @(negedge ap_clk);
        rdy_mode = 0;
        wait_drain();

        // Reset in the middle of CALC aborts the operation
        issue(1000, 7, 1'b0);
        repeat (12) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        issue(1000, 7, 1'b1);
        wait_drain();

        // Randomised operations, with random consumer stalls
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            t = 27'($urandom);
            if (($urandom % 3) == 0) begin
                a = int'($urandom_range(0, 200000));
                if ($urandom % 2) a = -a;
            end else begin
                a = int'($signed(t));
            end
            if (($urandom % 8) == 0) b = 0;
            else                     b = int'($urandom_range(1, 2047));
            issue(a, b, 1'b1);
            if (($urandom % 2) == 0) wait_drain();
        end
        rdy_mode = 0;
        wait_drain();

        repeat (3) @(posedge ap_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
